// File: rtl/decodificador_hamming_if.sv
// Handshake bus between a SECDED Hamming(8,4) decoder and its neighbours.
//   slave  : decoder side (takes palabra, returns decoded data and error flags)
//   master : environment side (drives palabra/valido_entrada and listo_salida)
// Signals:
//   palabra, valido_entrada, listo_entrada         upstream valid/ready channel
//   dato_salida, sindrome, error_corregido,
//   error_doble, valido_salida, listo_salida       downstream valid/ready channel
interface decodificador_hamming_if;
  logic [7:0] palabra;
  logic       valido_entrada;
  logic       listo_entrada;
  logic [3:0] dato_salida;
  logic [2:0] sindrome;
  logic       error_corregido;
  logic       error_doble;
  logic       valido_salida;
  logic       listo_salida;

  modport slave (
    input  palabra,
    input  valido_entrada,
    input  listo_salida,
    output listo_entrada,
    output dato_salida,
    output sindrome,
    output error_corregido,
    output error_doble,
    output valido_salida
  );

  modport master (
    output palabra,
    output valido_entrada,
    output listo_salida,
    input  listo_entrada,
    input  dato_salida,
    input  sindrome,
    input  error_corregido,
    input  error_doble,
    input  valido_salida
  );
endinterface

// File: rtl/decodificador_hamming.sv
// SECDED decoder for extended Hamming(8,4) code words.
// Two-stage pipeline: stage 1 registers the word with its syndrome and overall parity,
// stage 2 registers the corrected data and error flags. Both stages advance together
// whenever the output register is empty or being consumed.
// Ports:
//   reloj               clock, rising edge
//   reset_n             synchronous active-low reset
//   canal               decodificador_hamming_if.slave handshake bus
//   limpiar_contadores  synchronous clear of both error counters
//   cuenta_corregidos   saturating count of delivered words with error_corregido
//   cuenta_dobles       saturating count of delivered words with error_doble
// Optional build macro HAMMING_CONTADORES_EN: builds the error counters. Without it
// the counter outputs are tied to 0 and limpiar_contadores is ignored.
// Word layout: b0 overall parity, b1/b2/b4 = p1/p2/p4, b3/b5/b6/b7 = dato[0..3].
module decodificador_hamming #(
  parameter int unsigned ANCHO_CONT = 16
) (
  input  logic                    reloj,
  input  logic                    reset_n,
  decodificador_hamming_if.slave  canal,
  input  logic                    limpiar_contadores,
  output logic [ANCHO_CONT-1:0]   cuenta_corregidos,
  output logic [ANCHO_CONT-1:0]   cuenta_dobles
);

  logic       avanza;

  // Stage 1 state
  logic       s1_valido_q;
  logic [7:0] s1_palabra_q;
  logic [2:0] s1_sindrome_q;
  logic       s1_paridad_q;

  // Stage 2 state (drives the outputs directly)
  logic       s2_valido_q;
  logic [3:0] dato_q;
  logic [2:0] sindrome_q;
  logic       corregido_q;
  logic       doble_q;

  logic [2:0] sindrome_d;
  logic       paridad_d;
  logic [7:0] corregida;
  logic       corregido_d;
  logic       doble_d;

  assign avanza = !s2_valido_q || canal.listo_salida;

  assign sindrome_d = {canal.palabra[4] ^ canal.palabra[5] ^ canal.palabra[6] ^ canal.palabra[7],
                       canal.palabra[2] ^ canal.palabra[3] ^ canal.palabra[6] ^ canal.palabra[7],
                       canal.palabra[1] ^ canal.palabra[3] ^ canal.palabra[5] ^ canal.palabra[7]};
  assign paridad_d  = ^canal.palabra;

  // Odd overall parity means a single flip: at position s, or at b0 when s == 0.
  // Even parity with a nonzero syndrome is an uncorrectable double error; the raw
  // data bits are passed through in that case.
  always_comb begin
    corregida   = s1_palabra_q;
    corregido_d = 1'b0;
    doble_d     = 1'b0;
    if (s1_paridad_q) begin
      corregido_d = 1'b1;
      if (s1_sindrome_q != 3'd0) begin
        corregida[s1_sindrome_q] = ~s1_palabra_q[s1_sindrome_q];
      end
    end else if (s1_sindrome_q != 3'd0) begin
      doble_d = 1'b1;
    end
  end

  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      s1_valido_q   <= 1'b0;
      s1_palabra_q  <= 8'd0;
      s1_sindrome_q <= 3'd0;
      s1_paridad_q  <= 1'b0;
      s2_valido_q   <= 1'b0;
      dato_q        <= 4'd0;
      sindrome_q    <= 3'd0;
      corregido_q   <= 1'b0;
      doble_q       <= 1'b0;
    end else if (avanza) begin
      s1_valido_q   <= canal.valido_entrada;
      s1_palabra_q  <= canal.palabra;
      s1_sindrome_q <= sindrome_d;
      s1_paridad_q  <= paridad_d;
      s2_valido_q   <= s1_valido_q;
      dato_q        <= {corregida[7], corregida[6], corregida[5], corregida[3]};
      sindrome_q    <= s1_sindrome_q;
      corregido_q   <= corregido_d;
      doble_q       <= doble_d;
    end
  end

  assign canal.listo_entrada   = avanza;
  assign canal.valido_salida   = s2_valido_q;
  assign canal.dato_salida     = dato_q;
  assign canal.sindrome        = sindrome_q;
  assign canal.error_corregido = corregido_q;
  assign canal.error_doble     = doble_q;

`ifdef HAMMING_CONTADORES_EN
  localparam logic [ANCHO_CONT-1:0] CuentaMax = '1;
  localparam logic [ANCHO_CONT-1:0] CuentaUno = {{(ANCHO_CONT-1){1'b0}}, 1'b1};

  logic                  salida_xfer;
  logic [ANCHO_CONT-1:0] corr_cnt_q;
  logic [ANCHO_CONT-1:0] doble_cnt_q;

  assign salida_xfer = s2_valido_q && canal.listo_salida;

  // Clear wins over a simultaneous increment; counts stick at all-ones.
  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      corr_cnt_q  <= '0;
      doble_cnt_q <= '0;
    end else if (limpiar_contadores) begin
      corr_cnt_q  <= '0;
      doble_cnt_q <= '0;
    end else if (salida_xfer) begin
      if (corregido_q && (corr_cnt_q != CuentaMax)) begin
        corr_cnt_q <= corr_cnt_q + CuentaUno;
      end
      if (doble_q && (doble_cnt_q != CuentaMax)) begin
        doble_cnt_q <= doble_cnt_q + CuentaUno;
      end
    end
  end

  assign cuenta_corregidos = corr_cnt_q;
  assign cuenta_dobles     = doble_cnt_q;
`else
  logic unused_limpiar;
  assign unused_limpiar    = limpiar_contadores;
  assign cuenta_corregidos = '0;
  assign cuenta_dobles     = '0;
`endif

endmodule

// File: doc/decodificador_hamming.md
Name: decodificador_hamming

Overview:
- SECDED decoder for the 8-bit extended Hamming(8,4) words produced by Codificador; the inverse direction of that encoder.
- Computes syndrome and overall parity, corrects any single-bit error, flags double-bit errors, and returns the 4-bit data word.
- 2-stage pipeline with a valid/ready handshake on both sides, plus saturating error-statistics counters.

Parameters:
- ANCHO_CONT, 16, width of each error counter.

Ports:
- reloj  input  1  clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- palabra  input  8  received code word.
- valido_entrada  input  1  palabra is valid this cycle.
- listo_entrada  output  1  decoder accepts palabra this cycle.
- dato_salida  output  4  decoded (corrected) data.
- sindrome  output  3  Hamming syndrome of the word (position of the flipped bit, 0 = none).
- error_corregido  output  1  single error was corrected (data or parity bit).
- error_doble  output  1  uncorrectable double error detected.
- valido_salida  output  1  outputs are valid.
- listo_salida  input  1  downstream accepts the output this cycle.
- limpiar_contadores  input  1  synchronous clear of both counters.
- cuenta_corregidos  output  ANCHO_CONT  number of delivered words with error_corregido.
- cuenta_dobles  output  ANCHO_CONT  number of delivered words with error_doble.

Behaviour:
- Bit layout: palabra[0] is the overall even parity over bits [7:0]. palabra[1], [2] and [4] are p1, p2 and p4. palabra[3], [5], [6] and [7] carry dato[0] through dato[3].
- Parity equations: p1 = b3^b5^b7; p2 = b3^b6^b7; p4 = b5^b6^b7.
- Syndrome: s[0] = b1^b3^b5^b7; s[1] = b2^b3^b6^b7; s[2] = b4^b5^b6^b7.
- Overall parity: par = XOR of b[7:0].
- Classification:
  - s=0, par=0: no error.
  - s≠0, par=1: single error at bit s. Flip it, set error_corregido.
  - s=0, par=1: error in b0 only. Data is unchanged, set error_corregido.
  - s≠0, par=0: double error. Set error_doble and output the uncorrected data bits.
  - error_corregido and error_doble are never both 1.
- Pipeline:
  - avanza = !valido_salida || listo_salida.
  - listo_entrada = avanza (combinational).
  - When avanza = 1:
    - Stage 1 captures palabra, valido_entrada, syndrome and parity.
    - Stage 2 captures the correction results from stage 1.
  - When avanza = 0, both stages hold.
  - Latency: 2 cycles from an accepted input to valido_salida when there is no backpressure.
  - Throughput: 1 word/cycle.
  - Outputs are registered and stay stable while valido_salida=1 and listo_salida=0.
- Transfer rules:
  - An input transfer occurs when valido_entrada && listo_entrada.
  - An output transfer occurs when valido_salida && listo_salida.
  - A word with valido_entrada=0 is a bubble: its stage valid bit is 0.
- Reset (reset_n=0 at the clock edge):
  - All stage valid bits, dato_salida, sindrome, error flags and both counters go to 0.
  - Reset mid-operation discards all in-flight words.
  - listo_entrada reads 1 after reset.
- Counters:
  - Increment only on an output transfer, according to the corresponding flag.
  - Saturate at all-ones; no wrap-around.
  - limpiar_contadores=1 clears both counters and has priority over a simultaneous increment.

Optional Feature:
- Macro HAMMING_CONTADORES_EN.
- When defined: the counters are implemented as described above.
- When undefined: no counter registers are built, cuenta_corregidos and cuenta_dobles are tied to 0, and limpiar_contadores is ignored. Decoding behaviour is unchanged.

Test Plan:
- Reset, then send 8'hA5, 8'h33 and 8'hCC on consecutive cycles with listo_salida=1 -> outputs 4'b1010, 4'b0010 and 4'b1101 on cycles 2, 3 and 4. sindrome=0, no error flags.
- 8'h85 (8'hA5 with bit 5 flipped) -> dato_salida=4'b1010, sindrome=3'd5, error_corregido=1. 8'hA4 (bit 0 flipped) -> dato_salida=4'b1010, sindrome=0, error_corregido=1.
- 8'hA3 (8'hA5 with bits 1 and 2 flipped) -> sindrome=3'd3, error_doble=1, error_corregido=0. With the macro defined, cuenta_dobles increments by 1.
- Backpressure: hold listo_salida=0 for 4 cycles while streaming -> listo_entrada=0 and outputs stable. Release -> all words are delivered in order with none lost or duplicated.
- Counters with the macro defined:
  - Force 2^ANCHO_CONT+3 corrected words -> cuenta_corregidos saturates at all-ones.
  - Assert limpiar_contadores in the same cycle as an output transfer with a corrected error -> counter reads 0.
- Assert reset_n=0 with two words in flight -> valido_salida=0 on the next cycle and no stale word is output after release.
